branch_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters for the 5-stage pipeline. Lookup is combinational in IF and returns the predicted next PC. Training comes from the branch resolver in EX, which asserts `upd_en = ~ID_EX_Flush`. A bulk-invalidate sequencer clears the table one entry per cycle on request.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/sat_counter2.sv | 24 ++
 rtl/branch_predictor.sv | 140 ++++++++++++++
 tb/tb_branch_predictor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch target buffer.
// Optional feature macro: BP_GSHARE_EN (see branch_predictor.sv).
package bp_pkg;

   localparam int unsigned BP_ENTRIES = 16;
   localparam int unsigned BP_IDX_W   = 4;

   // 2-bit direction counter encodings
   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Tag is stored right-justified in a 30-bit field; for a given IDX_W only
   // the low 32-IDX_W-2 bits are ever non-zero.
   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      logic [31:0] target;
      logic [1:0]  ctr;
   } bp_entry_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } bp_state_e;

endpackage

// File: rtl/sat_counter2.sv
// Next-value function of a 2-bit saturating direction counter.
// Ports: ctr (current value), taken (resolved direction),
//        force_strong (jump: force strongly taken), ctr_next_c (next value).
module sat_counter2
   import bp_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   input  logic       force_strong,
   output logic [1:0] ctr_next_c
);

   always_comb begin
      ctr_next_c = ctr;
      if (force_strong) begin
         ctr_next_c = ST;
      end else if (taken) begin
         if (ctr != ST) ctr_next_c = ctr + 2'd1;
      end else begin
         if (ctr != SNT) ctr_next_c = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Combinational lookup (pc -> pred_taken/pred_addr), training from EX
// (upd_*), and a one-entry-per-cycle bulk invalidate (inv_req/inv_busy).
// Optional macro BP_GSHARE_EN: XOR an IDX_W-bit global branch history into
// both lookup and update indices.
// Ports: clk, rst (async, active-high), pc, pred_taken, pred_addr,
//        upd_valid, upd_en, upd_is_branch, upd_pc, upd_taken, upd_target,
//        inv_req, inv_busy.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES = BP_ENTRIES,
   parameter int unsigned IDX_W   = BP_IDX_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic        pred_taken,
   output logic [31:0] pred_addr,
   input  logic        upd_valid,
   input  logic        upd_en,
   input  logic        upd_is_branch,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        inv_req,
   output logic        inv_busy
);

   bp_entry_t           tbl_q [ENTRIES];
   bp_entry_t           tbl_d [ENTRIES];
   bp_state_e           state_q, state_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;

   logic [IDX_W-1:0]    lk_idx, up_idx;
   logic [29:0]         lk_tag, up_tag;
   bp_entry_t           lk_entry, up_entry;
   logic                lk_hit, up_hit, upd_accept;
   logic [1:0]          up_ctr_nxt;
   logic                upd_pc_lo_unused;

   // Instruction PCs are word aligned; the low bits carry no information.
   assign upd_pc_lo_unused = ^upd_pc[1:0];

`ifdef BP_GSHARE_EN
   logic [IDX_W-1:0]    ghr_q, ghr_d;
   assign lk_idx = pc[IDX_W+1:2] ^ ghr_q;
   assign up_idx = upd_pc[IDX_W+1:2] ^ ghr_q;
`else
   assign lk_idx = pc[IDX_W+1:2];
   assign up_idx = upd_pc[IDX_W+1:2];
`endif

   assign lk_tag = 30'(pc[31:IDX_W+2]);
   assign up_tag = 30'(upd_pc[31:IDX_W+2]);

   // Lookup reads the pre-edge table, so a same-cycle update is not bypassed.
   assign lk_entry   = tbl_q[lk_idx];
   assign lk_hit     = lk_entry.valid && (lk_entry.tag == lk_tag);
   assign pred_taken = (state_q == IDLE) && lk_hit && lk_entry.ctr[1];
   assign pred_addr  = pred_taken ? lk_entry.target : (pc + 32'd4);

   assign inv_busy   = (state_q == CLEAR);
   assign upd_accept = upd_valid && upd_en && (state_q == IDLE);
   assign up_entry   = tbl_q[up_idx];
   assign up_hit     = up_entry.valid && (up_entry.tag == up_tag);

   sat_counter2 u_ctr (
      .ctr          (up_ctr_nxt_src()),
      .taken        (upd_taken),
      .force_strong (!upd_is_branch),
      .ctr_next_c   (up_ctr_nxt)
   );

   function automatic logic [1:0] up_ctr_nxt_src();
      return up_entry.ctr;
   endfunction

   // Next-state: training in IDLE, one entry cleared per cycle in CLEAR.
   always_comb begin
      tbl_d   = tbl_q;
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef BP_GSHARE_EN
      ghr_d   = ghr_q;
`endif
      case (state_q)
         IDLE: begin
            if (upd_accept) begin
               if (up_hit) begin
                  tbl_d[up_idx].ctr = up_ctr_nxt;
                  if (upd_taken) tbl_d[up_idx].target = upd_target;
               end else if (upd_taken) begin
                  tbl_d[up_idx].valid  = 1'b1;
                  tbl_d[up_idx].tag    = up_tag;
                  tbl_d[up_idx].target = upd_target;
                  tbl_d[up_idx].ctr    = upd_is_branch ? WT : ST;
               end
`ifdef BP_GSHARE_EN
               if (upd_is_branch) ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
`endif
            end
            // A same-edge update still lands; the sweep erases it afterwards.
            if (inv_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            tbl_d[cnt_q].valid = 1'b0;
            tbl_d[cnt_q].ctr   = WNT;
            cnt_d              = cnt_q + IDX_W'(1);
            if (cnt_q == IDX_W'(ENTRIES - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset wipes valid/ctr and aborts any sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
         end
         state_q <= IDLE;
         cnt_q   <= '0;
`ifdef BP_GSHARE_EN
         ghr_q   <= '0;
`endif
      end else begin
         tbl_q   <= tbl_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef BP_GSHARE_EN
         ghr_q   <= ghr_d;
`endif
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic, compared every cycle against an array-based behavioural model.
module tb_branch_predictor;

   localparam int unsigned ENTRIES = 16;
   localparam int unsigned IDX_W   = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        pred_taken;
   logic [31:0] pred_addr;
   logic        upd_valid, upd_en, upd_is_branch, upd_taken;
   logic [31:0] upd_pc, upd_target;
   logic        inv_req;
   logic        inv_busy;

   always #5 clk = ~clk;

   branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .pc(pc), .pred_taken(pred_taken), .pred_addr(pred_addr),
      .upd_valid(upd_valid), .upd_en(upd_en), .upd_is_branch(upd_is_branch),
      .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .inv_req(inv_req), .inv_busy(inv_busy)
   );

   // Behavioural model
   bit          m_valid  [ENTRIES];
   logic [31:0] m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_ctr    [ENTRIES];
   int          m_clear_left;
   int unsigned m_ghr;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int unsigned m_index(input logic [31:0] a);
      int unsigned r;
      r = (a >> 2) % ENTRIES;
`ifdef BP_GSHARE_EN
      r = r ^ m_ghr;
`endif
      return r;
   endfunction

   function automatic logic [31:0] m_tagof(input logic [31:0] a);
      return a >> (IDX_W + 2);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < int'(ENTRIES); i++) begin
         m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 1;
      end
      m_clear_left = 0;
      m_ghr = 0;
   endtask

   // Apply one clock edge to the model using the inputs present at that edge.
   task automatic model_edge();
      int unsigned idx;
      bit hit;
      if (rst) begin
         m_reset();
      end else if (m_clear_left > 0) begin
         idx = ENTRIES - m_clear_left;
         m_valid[idx] = 1'b0;
         m_ctr[idx] = 1;
         m_clear_left--;
      end else begin
         if (upd_valid && upd_en) begin
            idx = m_index(upd_pc);
            hit = m_valid[idx] && (m_tag[idx] == m_tagof(upd_pc));
            if (hit) begin
               if (!upd_is_branch)  m_ctr[idx] = 3;
               else if (upd_taken)  m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
               else                 m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
               if (upd_taken) m_target[idx] = upd_target;
            end else if (upd_taken) begin
               m_valid[idx] = 1'b1;
               m_tag[idx] = m_tagof(upd_pc);
               m_target[idx] = upd_target;
               m_ctr[idx] = upd_is_branch ? 2 : 3;
            end
            if (upd_is_branch) m_ghr = ((m_ghr << 1) | 32'(upd_taken)) % ENTRIES;
         end
         if (inv_req) m_clear_left = ENTRIES;
      end
   endtask

   task automatic compare_outputs();
      int unsigned idx;
      bit          e_taken;
      logic [31:0] e_addr;
      idx     = m_index(pc);
      e_taken = (m_clear_left == 0) && m_valid[idx] && (m_tag[idx] == m_tagof(pc)) && (m_ctr[idx] >= 2);
      e_addr  = e_taken ? m_target[idx] : pc + 32'd4;
      chk("model_pred_taken", 32'(pred_taken), 32'(e_taken));
      chk("model_pred_addr", pred_addr, e_addr);
      chk("model_inv_busy", 32'(inv_busy), 32'(m_clear_left > 0));
   endtask

   // One cycle: check outputs mid-low-phase, clock, advance model.
   task automatic tick();
      #1 compare_outputs();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // Hand-computed literal expectations for the default (non-gshare) build.
   task automatic lit(input string name, input logic t, input logic [31:0] a);
      #1;
`ifndef BP_GSHARE_EN
      chk({name, "_taken"}, 32'(pred_taken), 32'(t));
      chk({name, "_addr"}, pred_addr, a);
`endif
   endtask

   task automatic set_upd(input logic v, input logic en, input logic br,
                          input logic [31:0] p, input logic tk, input logic [31:0] tg);
      upd_valid = v; upd_en = en; upd_is_branch = br; upd_pc = p; upd_taken = tk; upd_target = tg;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      if ($urandom_range(0, 19) == 0) a = $urandom();
      else a = (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2)
               | 32'($urandom_range(0, 3));
      return a;
   endfunction

   initial begin
      int n;
      rst = 1'b1; pc = 32'h100; inv_req = 1'b0;
      set_upd(0, 0, 0, 0, 0, 0);
      m_reset();
      @(negedge clk);
      lit("reset", 1'b0, 32'h104);
      chk("reset_busy", 32'(inv_busy), 32'd0);
      tick();
      rst = 1'b0;
      lit("after_reset", 1'b0, 32'h104);

      // Allocate 0x100 -> 0x200; same-cycle lookup sees old contents.
      set_upd(1, 1, 1, 32'h100, 1, 32'h200);
      lit("same_cycle", 1'b0, 32'h104);
      tick();
      set_upd(0, 0, 0, 0, 0, 0);
      lit("alloc", 1'b1, 32'h200);

      // 10 -> 01 -> 00, then taken once stays weak (01): saturation at 00.
      set_upd(1, 1, 1, 32'h100, 0, 32'h0);
      tick();
      lit("nt1", 1'b0, 32'h104);
      tick();
      lit("nt2", 1'b0, 32'h104);
      set_upd(1, 1, 1, 32'h100, 1, 32'h200);
      tick();
      lit("t_from_snt", 1'b0, 32'h104);
      tick();
      set_upd(0, 0, 0, 0, 0, 0);
      lit("t_to_wt", 1'b1, 32'h200);

      // Alias: same index, different tag.
      pc = 32'h140;
      lit("alias", 1'b0, 32'h144);
      tick();

      // Wrap of pc+4.
      pc = 32'hFFFF_FFFC;
      lit("wrap", 1'b0, 32'h0);
      tick();

      // Flushed update must not allocate.
      set_upd(1, 0, 1, 32'h104, 1, 32'h300);
      tick();
      set_upd(0, 0, 0, 0, 0, 0);
      pc = 32'h104;
      lit("flushed", 1'b0, 32'h108);
      tick();

      // Full invalidate; update in busy cycle 5 and re-request in cycle 8 are ignored.
      pc = 32'h100;
      lit("pre_inv", 1'b1, 32'h200);
      inv_req = 1'b1;
      tick();
      inv_req = 1'b0;
      n = 0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 5) set_upd(1, 1, 1, 32'h100, 1, 32'h300);
         if (c == 8) inv_req = 1'b1;
         #1;
         if (inv_busy) n++;
         tick();
         set_upd(0, 0, 0, 0, 0, 0);
         inv_req = 1'b0;
      end
      chk("inv_len", 32'(n), 32'd16);
      lit("post_inv", 1'b0, 32'h104);

      // Second invalidate aborted by reset in busy cycle 8.
      set_upd(1, 1, 0, 32'h100, 1, 32'h240);
      tick();
      set_upd(0, 0, 0, 0, 0, 0);
      inv_req = 1'b1;
      tick();
      inv_req = 1'b0;
      for (int c = 1; c < 8; c++) tick();
      chk("busy_before_rst", 32'(inv_busy), 32'd1);
      #2 rst = 1'b1;
      m_reset();
      #1 chk("rst_abort_busy", 32'(inv_busy), 32'd0);
      tick();
      rst = 1'b0;
      lit("after_abort", 1'b0, 32'h104);
      tick();

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         pc = rand_addr();
         upd_valid = ($urandom_range(0, 1) == 1);
         upd_en = ($urandom_range(0, 4) != 0);
         upd_is_branch = ($urandom_range(0, 9) < 7);
         upd_taken = upd_is_branch ? 1'($urandom_range(0, 1)) : 1'b1;
         upd_pc = rand_addr();
         upd_target = $urandom() & 32'hFFFF_FFFC;
         inv_req = ($urandom_range(0, 99) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
